// File: rtl/frog_pkg.sv
// Shared types and constants for the frog movement arbiter.
package frog_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    COOL  = 2'd2
  } arb_state_t;

  localparam logic [7:0] DROP_MAX = 8'd255;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/frog_move_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker over the four directions.
// The search starts one position past the last grant and wraps modulo 4.
module rr_pick4
  import frog_pkg::*;
(
  input  logic [3:0] req,
  input  dir_t       last,
  output logic       gnt_valid,
  output dir_t       gnt_dir
);

  logic [1:0] w_idx;

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can infer a latch.
    gnt_valid = 1'b0;
    gnt_dir   = DIR_UP;
    w_idx     = 2'd0;
    // Farthest candidate first, so the nearest pending direction is assigned last and wins.
    for (int k = 4; k >= 1; k--) begin
      w_idx = 2'(int'(last) + k);
      if (req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_dir   = dir_t'(w_idx);
      end
    end
  end

endmodule

// File: rtl/frog_move_arbiter.sv
// frog_move_arbiter: latches button presses and offers one move at a time with a tick cooldown.
// Optional FROG_OPPOSITE_CANCEL_EN: simultaneously pending opposite directions cancel each other.
module frog_move_arbiter
  import frog_pkg::*;
#(
  parameter int unsigned COOLDOWN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_pulse,
  input  logic       tick,
  input  logic       enable,
  input  logic       move_ready,
  output logic       move_valid,
  output dir_t       move_dir,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] COOL_INIT = 8'(COOLDOWN);

  arb_state_t r_state, w_state_next;
  logic [3:0] r_pend, w_pend_next;
  dir_t       r_last, w_last_next;
  dir_t       r_dir, w_dir_next;
  logic       r_valid, w_valid_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic [7:0] r_drop, w_drop_next;

  logic       w_hs;
  logic [3:0] w_clr, w_merged, w_cancel, w_drop_bits;
  logic [8:0] w_drop_sum;
  logic       w_pick_valid;
  dir_t       w_pick_dir;

  rr_pick4 u_pick (
    .req      (r_pend),
    .last     (r_last),
    .gnt_valid(w_pick_valid),
    .gnt_dir  (w_pick_dir)
  );

  // Disabling the game aborts an offer even if ready is high in the same cycle.
  assign w_hs     = r_valid & move_ready & enable;
  assign w_clr    = w_hs ? (4'b0001 << r_dir) : 4'b0000;
  assign w_merged = (r_pend & ~w_clr) | btn_pulse;

`ifdef FROG_OPPOSITE_CANCEL_EN
  logic w_protect;
  assign w_protect = (r_state == OFFER) & ~w_hs;

  always_comb begin
    w_cancel = 4'b0000;
    // The direction on offer survives; only its opposite is dropped.
    if (w_merged[0] & w_merged[1])
      w_cancel[1:0] = (w_protect && !r_dir[1]) ? ~(2'b01 << r_dir[0]) : 2'b11;
    if (w_merged[2] & w_merged[3])
      w_cancel[3:2] = (w_protect && r_dir[1]) ? ~(2'b01 << r_dir[0]) : 2'b11;
  end
`else
  assign w_cancel = 4'b0000;
`endif

  assign w_pend_next = enable ? (w_merged & ~w_cancel) : 4'b0000;
  assign w_drop_bits = btn_pulse & r_pend & ~w_clr & ~w_cancel;
  assign w_drop_sum  = {1'b0, r_drop} + {6'd0, popcount4(w_drop_bits)};
  assign w_drop_next = (w_drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : w_drop_sum[7:0];

  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_dir_next   = r_dir;
    w_last_next  = r_last;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (enable && w_pick_valid) begin
          w_valid_next = 1'b1;
          w_dir_next   = w_pick_dir;
          w_state_next = OFFER;
        end
      end
      OFFER: begin
        if (!enable) begin
          w_valid_next = 1'b0;
          w_state_next = IDLE;
        end else if (move_ready) begin
          w_valid_next = 1'b0;
          w_last_next  = r_dir;
          w_cnt_next   = COOL_INIT;
          w_state_next = (COOL_INIT == 8'd0) ? IDLE : COOL;
        end
      end
      COOL: begin
        if (tick) begin
          if (r_cnt == 8'd1) w_state_next = IDLE;
          else               w_cnt_next   = r_cnt - 8'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pend  <= 4'b0000;
      r_last  <= DIR_RIGHT;
      r_dir   <= DIR_UP;
      r_valid <= 1'b0;
      r_cnt   <= 8'd0;
      r_drop  <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      r_last  <= w_last_next;
      r_dir   <= w_dir_next;
      r_valid <= w_valid_next;
      r_cnt   <= w_cnt_next;
      r_drop  <= w_drop_next;
    end
  end

  assign move_valid = r_valid;
  assign move_dir   = r_dir;
  assign busy       = (r_state != IDLE);
  assign drop_cnt   = r_drop;

endmodule
